// File: rtl/pll_phase_ctrl_if.sv
// Phase-shift request handshake between a requester (master) and pll_phase_ctrl (slave).
interface pll_phase_ctrl_if #(
    parameter int unsigned STEP_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_sel;
    logic              req_dir;
    logic [STEP_W-1:0] req_steps;

    modport master (output req_valid, req_sel, req_dir, req_steps, input req_ready);
    modport slave  (input req_valid, req_sel, req_dir, req_steps, output req_ready);
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 PLL dynamic-phase sequencer with lock filtering and downstream reset generation.
// Optional macro PLL_PHASE_TRACK_EN adds per-channel signed phase_pos step totals.
module pll_phase_ctrl #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned LOCK_HOLD = 16,
    parameter int unsigned STEP_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    pll_phase_ctrl_if.slave        req,
    output logic [1:0]             phasesel,
    output logic                   phasedir,
    output logic                   phasestep,
    output logic                   busy,
    output logic                   done,
    output logic                   abort,
    output logic                   lock_ok,
    output logic                   rst_out_n,
`ifdef PLL_PHASE_TRACK_EN
    output logic signed [15:0]     phase_pos [4],
`endif
    output logic [7:0]             loss_cnt
);

    localparam int unsigned MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_C  = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
    localparam int unsigned CNT_W  = $clog2(MAX_C + 1);
    localparam int unsigned HOLD_W = $clog2(LOCK_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        DONE,
        ABORT
    } state_e;

    logic              sync1_q;
    logic              lock_s_q;
    logic [HOLD_W-1:0] hold_q;
    logic              lock_ok_q;
    logic              lock_ok_d;
    logic              rst_out_q;
    logic [7:0]        loss_q;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STEP_W-1:0] remain_q;
    logic [1:0]        phasesel_q;
    logic              phasedir_q;
    logic              phasestep_q;
    logic              done_q;
    logic              abort_q;
    logic              req_ready_w;

    // Registered lock_ok rises on the same edge the hold counter reaches LOCK_HOLD.
    always_comb begin
        lock_ok_d = lock_s_q && (hold_q >= HOLD_W'(LOCK_HOLD - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            hold_q    <= '0;
            lock_ok_q <= 1'b0;
            rst_out_q <= 1'b0;
            loss_q    <= '0;
        end else begin
            sync1_q   <= pll_locked;
            lock_s_q  <= sync1_q;
            if (!lock_s_q) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_W'(LOCK_HOLD)) begin
                hold_q <= hold_q + 1'b1;
            end
            lock_ok_q <= lock_ok_d;
            rst_out_q <= lock_ok_q;
            if (lock_ok_q && !lock_ok_d && (loss_q != 8'hFF)) begin
                loss_q <= loss_q + 8'd1;
            end
        end
    end

    assign req_ready_w   = (state_q == IDLE) && lock_ok_q;
    assign req.req_ready = req_ready_w;

    // A pulse in flight is never truncated by lock loss; the abort check happens at its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            remain_q    <= '0;
            phasesel_q  <= '0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req.req_valid && req_ready_w) begin
                        phasesel_q <= req.req_sel;
                        phasedir_q <= req.req_dir;
                        remain_q   <= req.req_steps;
                        cnt_q      <= CNT_W'(SETUP_CYC - 1);
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (!lock_ok_q) begin
                        abort_q <= 1'b1;
                        state_q <= ABORT;
                    end else if (cnt_q == '0) begin
                        if (remain_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            phasestep_q <= 1'b1;
                            cnt_q       <= CNT_W'(PULSE_CYC - 1);
                            state_q     <= PULSE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        phasestep_q <= 1'b0;
                        if (!lock_ok_q) begin
                            abort_q <= 1'b1;
                            state_q <= ABORT;
                        end else begin
                            cnt_q   <= CNT_W'(GAP_CYC - 1);
                            state_q <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (!lock_ok_q) begin
                        abort_q <= 1'b1;
                        state_q <= ABORT;
                    end else if (cnt_q == '0) begin
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == STEP_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            phasestep_q <= 1'b1;
                            cnt_q       <= CNT_W'(PULSE_CYC - 1);
                            state_q     <= PULSE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ABORT: begin
                    abort_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    phasestep_q <= 1'b0;
                    done_q      <= 1'b0;
                    abort_q     <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

`ifdef PLL_PHASE_TRACK_EN
    logic signed [15:0] pos_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pos_q[i] <= '0;
            end
        end else if ((state_q == PULSE) && (cnt_q == '0)) begin
            pos_q[phasesel_q] <= phasedir_q ? (pos_q[phasesel_q] - 16'sd1)
                                            : (pos_q[phasesel_q] + 16'sd1);
        end
    end

    assign phase_pos = pos_q;
`endif

    assign phasesel  = phasesel_q;
    assign phasedir  = phasedir_q;
    assign phasestep = phasestep_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign abort     = abort_q;
    assign lock_ok   = lock_ok_q;
    assign rst_out_n = rst_out_q;
    assign loss_cnt  = loss_q;

endmodule
